// File: rtl/down_count_monitor_pkg.sv
// Shared definitions for the down-counter monitor: FSM states and default widths.
package down_count_monitor_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

endpackage

// File: rtl/evt_hold_reg.sv
// Single-entry valid/ready holding register; a load arriving while full is
// reported on overflow and the held value is kept.
module evt_hold_reg #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WRAP_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [WRAP_W-1:0] data,
  output logic              overflow
);

  logic xfer;

  assign xfer     = valid && ready;
  assign overflow = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && (!valid || xfer)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// Watches a free-running down counter: counts underflow wraps, flags restarts
// and sequence errors, and offers each wrap as an event to a downstream consumer.
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_q,
  input  logic              clear,
  output logic              wrap_pulse,
  output logic              restart_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [WRAP_W-1:0] evt_data,
  output logic              evt_drop
);

  localparam logic [CNT_W-1:0] ONES = '1;

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  prev, nxt_prev;
  logic              wrap_evt, restart_evt, err_set, overflow;
  logic [WRAP_W-1:0] wrap_cnt_inc;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wrap_cnt_inc = sat_inc(wrap_cnt);

  always_comb begin
    nxt_state   = state;
    nxt_prev    = prev;
    wrap_evt    = 1'b0;
    restart_evt = 1'b0;
    err_set     = 1'b0;
    if (clear) begin
      nxt_state = INIT;
    end else begin
      case (state)
        INIT: begin
          nxt_prev  = cnt_q;
          nxt_state = TRACK;
        end
        TRACK: begin
          // prev == 0 is excluded from the normal step so the all-ones
          // successor of zero is classified as a wrap.
          if (prev != '0 && cnt_q == prev - 1'b1) begin
            nxt_prev = cnt_q;
          end else if (cnt_q == ONES) begin
            nxt_prev    = cnt_q;
            wrap_evt    = (prev == '0);
            restart_evt = (prev != '0);
          end else begin
            err_set   = 1'b1;
            nxt_state = FAULT;
          end
        end
        default: nxt_state = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= INIT;
      prev          <= '0;
      wrap_cnt      <= '0;
      err           <= 1'b0;
      evt_drop      <= 1'b0;
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      state         <= nxt_state;
      prev          <= nxt_prev;
      wrap_pulse    <= wrap_evt;
      restart_pulse <= restart_evt;
      if (clear) begin
        wrap_cnt <= '0;
        err      <= 1'b0;
        evt_drop <= 1'b0;
      end else begin
        if (wrap_evt) wrap_cnt <= wrap_cnt_inc;
        if (err_set) err <= 1'b1;
        if (overflow) evt_drop <= 1'b1;
      end
    end
  end

  // The event carries the post-increment count, so it is loaded from the
  // same saturating increment that updates wrap_cnt.
  evt_hold_reg #(
    .WRAP_W(WRAP_W)
  ) u_evt_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (wrap_evt),
    .load_data(wrap_cnt_inc),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .data     (evt_data),
    .overflow (overflow)
  );

endmodule

// File: doc/down_count_monitor.md
DOWN_COUNT_MONITOR -- requirements
Module: down_count_monitor

Interface
REQ-001 Parameter CNT_W, default 4: width of the monitored down-counter value.
REQ-002 Parameter WRAP_W, default 8: width of the wrap counter and event payload.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-005 cnt_q  input  CNT_W  value from the upstream free-running down counter, sampled every cycle.
REQ-006 clear  input  1  synchronous clear of wrap_cnt, err, evt_drop; returns the FSM to INIT.
REQ-007 wrap_pulse  output  1  one-cycle pulse per detected underflow wrap.
REQ-008 restart_pulse  output  1  one-cycle pulse when the upstream counter restarts at all-ones.
REQ-009 wrap_cnt  output  WRAP_W  saturating count of wraps.
REQ-010 err  output  1  sticky sequence-error flag.
REQ-011 evt_valid  output  1  event-holding register contains an event.
REQ-012 evt_ready  input  1  downstream accepts the event.
REQ-013 evt_data  output  WRAP_W  wrap_cnt value captured at the event.
REQ-014 evt_drop  output  1  sticky flag: an event was lost because the holding register was full.

Function
REQ-015 The FSM SHALL have three states: INIT, TRACK and FAULT. prev is an internal CNT_W register.
REQ-016 INIT: capture prev <= cnt_q and go to TRACK; no pulses and no checks.
REQ-017 TRACK, cnt_q == prev-1 (mod 2^CNT_W), prev != 0: normal step; prev <= cnt_q.
REQ-018 TRACK, prev == 0 and cnt_q == all-ones: wrap event.
  - wrap_pulse = 1 next cycle.
  - wrap_cnt += 1, saturating at 2^WRAP_W-1.
  - An event is offered with evt_data = the post-increment wrap_cnt.
REQ-019 TRACK, prev != 0 and cnt_q == all-ones: restart (upstream reset).
  - restart_pulse = 1 next cycle.
  - No wrap, no error; prev <= cnt_q.
REQ-020 TRACK, any other mismatch: err <= 1 and go to FAULT; no wrap or restart pulse.
REQ-021 FAULT: ignore cnt_q, hold all counters, keep issued events deliverable; leave only via clear or reset.
REQ-022 All outputs SHALL be registered. Pulses and the wrap_cnt update appear in the cycle after the edge that sampled the triggering cnt_q (latency 1).
REQ-023 Event handshake: a transfer occurs on an edge where evt_valid && evt_ready. After evt_valid rises, evt_valid and evt_data SHALL hold until that transfer.
REQ-024 New event with the register empty, or with a transfer on the same edge: load evt_data and set evt_valid = 1. Back-to-back events are lossless.
REQ-025 New event with the register full and no transfer: keep the old evt_data and set evt_drop <= 1.
REQ-026 clear has priority over all other events in its cycle.
  - wrap_cnt = 0, err = 0, evt_drop = 0, FSM = INIT.
  - The event register is not affected.
REQ-027 At wrap_cnt saturation, further wraps still pulse and still offer events with evt_data = max.

Reset
REQ-028 reset == 0 at an edge SHALL force the FSM to INIT and clear all registers.
  - prev = 0, wrap_cnt = 0, err = 0, evt_drop = 0, evt_valid = 0, evt_data = 0.
  - wrap_pulse = 0, restart_pulse = 0.
REQ-029 Reset SHALL override clear and evt_ready. A pending event is discarded without setting evt_drop.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (INIT, TRACK, FAULT) and the default CNT_W/WRAP_W constants.
REQ-031 The event holding register with valid/ready SHALL be a sub-module evt_hold_reg, parameterised by WRAP_W.

Verification
REQ-032 Reset, then drive cnt_q 3,2,1,0,15,14 with evt_ready=1 -> one wrap_pulse in the cycle after 15 is sampled; wrap_cnt=1; evt_data=1 for one cycle.
REQ-033 Drive cnt_q 9,8,15,14 -> restart_pulse once; wrap_pulse=0; err=0; wrap_cnt unchanged.
REQ-034 Drive cnt_q 6,5,3 -> err=1, FSM in FAULT; later wraps on cnt_q are ignored; clear -> err=0, INIT.
REQ-035 Hold evt_ready=0 across two wraps -> evt_data=1 retained, evt_drop=1; then evt_ready=1 -> one transfer, evt_valid=0.
REQ-036 WRAP_W=2, run 5 wraps -> wrap_cnt saturates at 3; 5 wrap_pulses; evt_data=3 for the last events.
REQ-037 Assert reset=0 mid-run with evt_valid=1 -> next cycle all outputs 0; first sample after release causes no pulse.
